// File: rtl/spi_frame_engine_pkg.sv
// Shared definitions for the SPI-slave frame engine: state encoding and
// small constant helpers used to size the shift and counter registers.
package spi_frame_engine_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ADDR      = 3'd1,
        ST_RD_LOAD   = 3'd2,
        ST_RD_SHIFT  = 3'd3,
        ST_WR_GET    = 3'd4,
        ST_WR_COMMIT = 3'd5,
        ST_DONE      = 3'd6
    } state_t;

    // Value of the rw bit (last bit of the address phase) that requests a read.
    localparam logic RW_READ = 1'b1;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_frame_engine_shift_reg.sv
// Generic shift register: MSB-first serial-in/parallel-out, or parallel-load
// and MSB-first serial-out (serial output is q[W-1]). Load has priority.
module spi_shift_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         shift_in_en,
    input  logic         serial_in,
    input  logic         load_en,
    input  logic [W-1:0] load_data,
    input  logic         shift_out_en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load_en) begin
            q <= load_data;
        end else if (shift_in_en) begin
            q <= {q[W-2:0], serial_in};
        end else if (shift_out_en) begin
            q <= {q[W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/spi_frame_engine.sv
// SPI-slave (mode 0, MSB first) frame decoder: one address/rw byte followed by
// one data byte per CS-low window, driven by pre-conditioned SCLK edge pulses.
module spi_frame_engine
    import spi_frame_engine_pkg::*;
#(
    parameter int ADDR_WIDTH = 7,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs_cond,
    input  logic                  sclk_posedge,
    input  logic                  sclk_negedge,
    input  logic                  mosi_cond,
    input  logic [WIDTH-1:0]      rd_data,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic [WIDTH-1:0]      wr_data,
    output logic                  wr_en,
    output logic                  miso_out,
    output logic                  miso_oe,
    output logic                  frame_done,
    output logic [2:0]            state_dbg
);

    localparam int RXW = max2(ADDR_WIDTH + 1, WIDTH);
    localparam int CW  = $clog2(max2(ADDR_WIDTH + 1, WIDTH) + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH);
    localparam logic [CW-1:0] DATA_LAST = CW'(WIDTH - 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [WIDTH-1:0]      wr_data_d;
    logic                  wr_en_d, miso_out_d, miso_oe_d, frame_done_d;

    logic                  rx_shift_en, tx_load_en, tx_shift_en;
    logic [RXW-1:0]        rx_q;
    logic [WIDTH-1:0]      tx_q;
    logic                  unused_tx_low;

    spi_shift_reg #(.W(RXW)) u_rx (
        .clk          (clk),
        .reset        (reset),
        .shift_in_en  (rx_shift_en),
        .serial_in    (mosi_cond),
        .load_en      (1'b0),
        .load_data    ({RXW{1'b0}}),
        .shift_out_en (1'b0),
        .q            (rx_q)
    );

    spi_shift_reg #(.W(WIDTH)) u_tx (
        .clk          (clk),
        .reset        (reset),
        .shift_in_en  (1'b0),
        .serial_in    (1'b0),
        .load_en      (tx_load_en),
        .load_data    (rd_data),
        .shift_out_en (tx_shift_en),
        .q            (tx_q)
    );

    // Only the MSB of the transmit register is ever presented on MISO.
    assign unused_tx_low = ^tx_q[WIDTH-2:0];
    assign state_dbg     = state_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr       <= '0;
            wr_data    <= '0;
            wr_en      <= 1'b0;
            miso_out   <= 1'b0;
            miso_oe    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr       <= addr_d;
            wr_data    <= wr_data_d;
            wr_en      <= wr_en_d;
            miso_out   <= miso_out_d;
            miso_oe    <= miso_oe_d;
            frame_done <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr;
        wr_data_d    = wr_data;
        wr_en_d      = 1'b0;
        miso_out_d   = miso_out;
        miso_oe_d    = miso_oe;
        frame_done_d = 1'b0;
        rx_shift_en  = 1'b0;
        tx_load_en   = 1'b0;
        tx_shift_en  = 1'b0;

        // CS deassertion aborts from any state and beats a coincident SCLK edge.
        if (cs_cond) begin
            state_d   = ST_IDLE;
            cnt_d     = '0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_ADDR;
                    cnt_d   = '0;
                end
                ST_ADDR: begin
                    if (sclk_posedge) begin
                        rx_shift_en = 1'b1;
                        // The bit arriving now is rw; the address bits are already in rx.
                        if (cnt_q == ADDR_LAST) begin
                            addr_d  = rx_q[ADDR_WIDTH-1:0];
                            cnt_d   = '0;
                            state_d = (mosi_cond == RW_READ) ? ST_RD_LOAD : ST_WR_GET;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_RD_LOAD: begin
                    tx_load_en = 1'b1;
                    miso_oe_d  = 1'b1;
                    state_d    = ST_RD_SHIFT;
                end
                ST_RD_SHIFT: begin
                    if (sclk_negedge) begin
                        tx_shift_en = 1'b1;
                        miso_out_d  = tx_q[WIDTH-1];
                        if (cnt_q == DATA_LAST) begin
                            cnt_d        = '0;
                            state_d      = ST_DONE;
                            frame_done_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WR_GET: begin
                    if (sclk_posedge) begin
                        rx_shift_en = 1'b1;
                        if (cnt_q == DATA_LAST) begin
                            cnt_d   = '0;
                            state_d = ST_WR_COMMIT;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                ST_WR_COMMIT: begin
                    wr_data_d    = rx_q[WIDTH-1:0];
                    wr_en_d      = 1'b1;
                    frame_done_d = 1'b1;
                    state_d      = ST_DONE;
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_engine.sv
// Self-checking bench for spi_frame_engine: directed frames plus random frames
// against a byte-level model of SPI frames and a reference memory.
module tb_spi_frame_engine;
    import spi_frame_engine_pkg::*;

    localparam int AW   = 7;
    localparam int W    = 8;
    localparam int HALF = 10;  // SCLK half-period of 200 ns at a 20 ns clk

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cs_cond = 1'b1;
    logic          sclk_posedge = 1'b0;
    logic          sclk_negedge = 1'b0;
    logic          mosi_cond = 1'b0;
    logic [W-1:0]  rd_data;
    logic [AW-1:0] addr;
    logic [W-1:0]  wr_data;
    logic          wr_en, miso_out, miso_oe, frame_done;
    logic [2:0]    state_dbg;

    logic [W-1:0]      env_mem [2**AW];
    logic [W-1:0]      ref_mem [2**AW];
    logic [AW+W-1:0]   exp_q[$];
    logic [AW-1:0]     exp_addr = '0;
    int                n_cmp = 0;
    int                n_err = 0;
    int                fd_seen = 0;
    int                fd_exp = 0;

    spi_frame_engine #(.ADDR_WIDTH(AW), .WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .cs_cond      (cs_cond),
        .sclk_posedge (sclk_posedge),
        .sclk_negedge (sclk_negedge),
        .mosi_cond    (mosi_cond),
        .rd_data      (rd_data),
        .addr         (addr),
        .wr_data      (wr_data),
        .wr_en        (wr_en),
        .miso_out     (miso_out),
        .miso_oe      (miso_oe),
        .frame_done   (frame_done),
        .state_dbg    (state_dbg)
    );

    // ---------------- clock / memory environment ----------------
    always #10 clk = ~clk;

    assign rd_data = env_mem[addr];

    always @(posedge clk) begin
        if (wr_en) env_mem[addr] <= wr_data;
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every write strobe must match the next expected {addr, data}.
    always @(negedge clk) begin
        if (frame_done) fd_seen++;
        if (wr_en) begin
            if (exp_q.size() > 0) check("wr_addr_data", 32'({addr, wr_data}), 32'(exp_q.pop_front()));
            else                  check("wr_en_spurious", 32'(wr_en), 32'(0));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic sclk_pulse(input bit rising);
        if (rising) sclk_posedge = 1'b1;
        else        sclk_negedge = 1'b1;
        tick();
        sclk_posedge = 1'b0;
        sclk_negedge = 1'b0;
    endtask

    // One CS-low window with nclk SCLK cycles; rst_at >= 0 pulses reset
    // at that SCLK cycle and abandons the frame.
    task automatic do_frame(input logic [7:0] ab, input logic [7:0] db,
                            input int nclk, input int rst_at);
        logic [7:0]    miso_b;
        logic          rw;
        logic [AW-1:0] a;
        bit            full;
        miso_b = '0;
        rw     = ab[0];
        a      = ab[7:1];
        full   = (nclk >= 16) && (rst_at < 0);

        if (full && !rw) begin
            exp_q.push_back({a, db});
            ref_mem[a] = db;
        end
        if (full) fd_exp++;
        if (rst_at >= 0)    exp_addr = '0;
        else if (nclk >= 8) exp_addr = a;

        cs_cond = 1'b0;
        wait_cycles(3);
        for (int i = 0; i < nclk; i++) begin
            if (i == rst_at) begin
                reset = 1'b1;
                tick();
                reset = 1'b0;
                check("rst_addr", 32'(addr), 32'(0));
                check("rst_miso_oe", 32'(miso_oe), 32'(0));
                check("rst_miso_out", 32'(miso_out), 32'(0));
                check("rst_wr_en", 32'(wr_en), 32'(0));
                check("rst_state", 32'(state_dbg), 32'(ST_IDLE));
                break;
            end
            if (i < 8)       mosi_cond = ab[7-i];
            else if (i < 16) mosi_cond = db[15-i];
            else             mosi_cond = 1'($urandom);
            wait_cycles(HALF - 1);
            if (i >= 8 && i < 16) miso_b[15-i] = miso_out;
            sclk_pulse(1'b1);
            wait_cycles(HALF - 1);
            sclk_pulse(1'b0);
        end
        wait_cycles(3);
        if (full && rw) begin
            check("miso_byte", 32'(miso_b), 32'(ref_mem[a]));
            check("miso_oe_done", 32'(miso_oe), 32'(1));
        end
        if (full) check("state_done", 32'(state_dbg), 32'(ST_DONE));

        cs_cond = 1'b1;
        tick();
        check("cs_state_idle", 32'(state_dbg), 32'(ST_IDLE));
        check("cs_miso_oe", 32'(miso_oe), 32'(0));
        check("addr_hold", 32'(addr), 32'(exp_addr));
        wait_cycles(50);
        check("frame_done_cnt", 32'(fd_seen), 32'(fd_exp));
        check("wr_pending", 32'(exp_q.size()), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        for (int i = 0; i < 2**AW; i++) begin
            logic [W-1:0] v;
            v = W'($urandom);
            env_mem[i] = v;
            ref_mem[i] = v;
        end

        wait_cycles(3);
        check("reset_addr", 32'(addr), 32'(0));
        check("reset_wr_data", 32'(wr_data), 32'(0));
        check("reset_wr_en", 32'(wr_en), 32'(0));
        check("reset_miso_out", 32'(miso_out), 32'(0));
        check("reset_miso_oe", 32'(miso_oe), 32'(0));
        check("reset_frame_done", 32'(frame_done), 32'(0));
        check("reset_state", 32'(state_dbg), 32'(ST_IDLE));
        reset = 1'b0;
        tick();

        // Basic write of 0xA5 to 0x2A.
        do_frame(8'h54, 8'hA5, 16, -1);
        // Read of 0x11 returning 0x3C.
        env_mem[7'h11] = 8'h3C;
        ref_mem[7'h11] = 8'h3C;
        do_frame(8'h23, 8'h00, 16, -1);
        // Write aborted after 4 data bits, then a complete write.
        do_frame(8'h54, 8'h99, 12, -1);
        do_frame(8'h54, 8'h66, 16, -1);
        // 20 SCLK cycles in one write frame.
        do_frame(8'h0C, 8'hC3, 20, -1);
        // Reset during the read data phase, then a normal read.
        do_frame(8'h23, 8'h00, 16, 12);
        do_frame(8'h23, 8'h00, 16, -1);
        // Back-to-back write then read of address 0x05.
        do_frame(8'h0A, 8'h7F, 16, -1);
        do_frame(8'h0B, 8'h00, 16, -1);

        for (int k = 0; k < 16; k++) begin
            logic [7:0] ab, db;
            int         sel, nclk;
            ab  = 8'($urandom);
            db  = 8'($urandom);
            sel = $urandom_range(0, 3);
            if (sel == 0)      nclk = $urandom_range(1, 15);
            else if (sel == 1) nclk = 20;
            else               nclk = 16;
            do_frame(ab, db, nclk, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
